// File: rtl/lsu_retire_tracker_if.sv
// Handshake bundle between issue/memory-return and the LSU retire tracker.
// The master side is issue plus the memory return path. The slave side is the tracker.
interface lsu_retire_tracker_if #(
  parameter int WFID_W = 6,
  parameter int CNT_W  = 4,
  parameter int OCC_W  = 4
);
  logic              lsu_valid;
  logic [WFID_W-1:0] lsu_wfid;
  logic [CNT_W-1:0]  lsu_rsp_cnt;
  logic              lsu_ready;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic              lsu_done;
  logic [WFID_W-1:0] lsu_done_wfid;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow_err;

  modport master (
    output lsu_valid, lsu_wfid, lsu_rsp_cnt, mem_rsp_valid,
    input  lsu_ready, mem_rsp_ready, lsu_done, lsu_done_wfid, occupancy, overflow_err
  );

  modport slave (
    input  lsu_valid, lsu_wfid, lsu_rsp_cnt, mem_rsp_valid,
    output lsu_ready, mem_rsp_ready, lsu_done, lsu_done_wfid, occupancy, overflow_err
  );
endinterface

// File: rtl/lsu_retire_tracker.sv
// In-order queue of issued LSU instructions. It counts down the response beats for each one
// and pulses lsu_done with the wavefront id once the instruction has fully retired.
module lsu_retire_tracker #(
  parameter int DEPTH  = 8,
  parameter int WFID_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_retire_tracker_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WFID_W-1:0] wfid_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ_q;
  logic              done_q;
  logic [WFID_W-1:0] done_wfid_q;
  logic              overflow_q;

  logic              head_valid;
  logic              full;
  logic              push;
  logic              beat;
  logic              retire;
  logic [CNT_W-1:0]  head_cnt;
  logic [WFID_W-1:0] head_wfid;

  always_comb begin
    head_valid = (occ_q != '0);
    full       = (occ_q == OCC_W'(DEPTH));
    head_cnt   = cnt_q[rd_ptr];
    head_wfid  = wfid_q[rd_ptr];
    push       = bus.lsu_valid && !full;
    beat       = bus.mem_rsp_valid && head_valid && (head_cnt != '0);
    retire     = head_valid && ((head_cnt == '0) || (beat && (head_cnt == CNT_W'(1))));
  end

  assign bus.lsu_ready     = !full;
  assign bus.mem_rsp_ready = head_valid && (head_cnt != '0);
  assign bus.lsu_done      = done_q;
  assign bus.lsu_done_wfid = done_wfid_q;
  assign bus.occupancy     = occ_q;
  assign bus.overflow_err  = overflow_q;

  // Payload storage needs no reset. Validity comes only from the occupancy count.
  // A push and a head decrement never hit the same slot, because a push into a
  // non-empty queue is only allowed when the queue is not full.
  always_ff @(posedge clk) begin
    if (push) begin
      wfid_q[wr_ptr] <= bus.lsu_wfid;
      cnt_q[wr_ptr]  <= bus.lsu_rsp_cnt;
    end
    if (beat && !retire) begin
      cnt_q[rd_ptr] <= head_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ_q       <= '0;
      done_q      <= 1'b0;
      done_wfid_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        done_wfid_q <= head_wfid;
      end
      done_q <= retire;
      case ({push, retire})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
      if (bus.lsu_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsu_retire_tracker.sv
// Directed bench for lsu_retire_tracker. Each expected value is worked out by hand, cycle by cycle.
module tb_lsu_retire_tracker;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  lsu_retire_tracker_if #(.WFID_W(6), .CNT_W(4), .OCC_W(4)) bus ();

  lsu_retire_tracker #(.DEPTH(8), .WFID_W(6), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] wfid, input logic [3:0] cnt,
                               input logic rsp_valid);
    bus.lsu_valid     = valid;
    bus.lsu_wfid      = wfid;
    bus.lsu_rsp_cnt   = cnt;
    bus.mem_rsp_valid = rsp_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back trace: pushes wfid 1,2,3 with counts 0,2,0 while the beat valid is held high.
  logic       t3_valid [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [5:0] t3_wfid  [6] = '{6'd1, 6'd2, 6'd3, 6'd0, 6'd0, 6'd0};
  logic [3:0] t3_cnt   [6] = '{4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
  logic       t3_done  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0] t3_dwfid [6] = '{6'd12, 6'd1, 6'd1, 6'd2, 6'd3, 6'd3};
  logic [3:0] t3_occ   [6] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd0, 4'd0};

  logic [3:0] beat_pat;
  logic       seen_done;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_occupancy", 32'(bus.occupancy), 0);
    checkOutput("reset_done", 32'(bus.lsu_done), 0);
    checkOutput("reset_done_wfid", 32'(bus.lsu_done_wfid), 0);
    checkOutput("reset_overflow", 32'(bus.overflow_err), 0);
    checkOutput("reset_ready", 32'(bus.lsu_ready), 1);
    checkOutput("reset_rsp_ready", 32'(bus.mem_rsp_ready), 0);
    rst = 1'b0;

    // A zero-count push retires two cycles later.
    applyStimulus(1'b1, 6'd5, 4'd0, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0);
    checkOutput("zc_done_t1", 32'(bus.lsu_done), 0);
    checkOutput("zc_occ_t1", 32'(bus.occupancy), 1);
    step();
    checkOutput("zc_done_t2", 32'(bus.lsu_done), 1);
    checkOutput("zc_wfid_t2", 32'(bus.lsu_done_wfid), 5);
    checkOutput("zc_occ_t2", 32'(bus.occupancy), 0);
    step();
    checkOutput("zc_done_t3", 32'(bus.lsu_done), 0);
    checkOutput("zc_wfid_hold", 32'(bus.lsu_done_wfid), 5);

    // Three beats with a gap. The instruction retires one cycle after the last beat.
    applyStimulus(1'b1, 6'd12, 4'd3, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0);
    checkOutput("b3_occ", 32'(bus.occupancy), 1);
    beat_pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rsp_valid = beat_pat[i];
      checkOutput($sformatf("b3_rsp_ready_%0d", i), 32'(bus.mem_rsp_ready), 1);
      step();
      if (i < 3) checkOutput($sformatf("b3_done_%0d", i), 32'(bus.lsu_done), 0);
    end
    bus.mem_rsp_valid = 1'b0;
    checkOutput("b3_done", 32'(bus.lsu_done), 1);
    checkOutput("b3_wfid", 32'(bus.lsu_done_wfid), 12);
    checkOutput("b3_rsp_ready_after", 32'(bus.mem_rsp_ready), 0);
    checkOutput("b3_occ_after", 32'(bus.occupancy), 0);
    step();
    checkOutput("b3_done_clear", 32'(bus.lsu_done), 0);

    // In-order retirement across a mix of zero-count and multi-beat entries.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t3_valid[i], t3_wfid[i], t3_cnt[i], 1'b1);
      step();
      checkOutput($sformatf("ord_done_%0d", i), 32'(bus.lsu_done), 32'(t3_done[i]));
      checkOutput($sformatf("ord_wfid_%0d", i), 32'(bus.lsu_done_wfid), 32'(t3_dwfid[i]));
      checkOutput($sformatf("ord_occ_%0d", i), 32'(bus.occupancy), 32'(t3_occ[i]));
    end

    // Fill the queue, then push while full.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 6'(30 + i), 4'd1, 1'b0);
      step();
    end
    applyStimulus(1'b1, 6'd39, 4'd1, 1'b0);
    checkOutput("full_occ", 32'(bus.occupancy), 8);
    checkOutput("full_ready", 32'(bus.lsu_ready), 0);
    checkOutput("full_overflow_pre", 32'(bus.overflow_err), 0);
    step();
    checkOutput("ovf_set", 32'(bus.overflow_err), 1);
    checkOutput("ovf_occ", 32'(bus.occupancy), 8);
    checkOutput("ovf_no_done", 32'(bus.lsu_done), 0);

    // Retire while full with a push pending. The push is dropped and the pop still happens.
    applyStimulus(1'b1, 6'd40, 4'd1, 1'b1);
    step();
    checkOutput("fullpop_occ", 32'(bus.occupancy), 7);
    checkOutput("fullpop_done", 32'(bus.lsu_done), 1);
    checkOutput("fullpop_wfid", 32'(bus.lsu_done_wfid), 30);
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput($sformatf("drain_done_%0d", i), 32'(bus.lsu_done), 1);
      checkOutput($sformatf("drain_wfid_%0d", i), 32'(bus.lsu_done_wfid), 32'(31 + i));
    end
    step();
    checkOutput("drain_end_done", 32'(bus.lsu_done), 0);
    checkOutput("drain_end_occ", 32'(bus.occupancy), 0);
    checkOutput("drain_end_wfid", 32'(bus.lsu_done_wfid), 37);
    checkOutput("overflow_sticky", 32'(bus.overflow_err), 1);

    // Reset with entries in flight discards them.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 6'(50 + i), 4'd2, 1'b0);
      step();
    end
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b0);
    checkOutput("inflight_occ", 32'(bus.occupancy), 4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_occ", 32'(bus.occupancy), 0);
    checkOutput("midrst_done", 32'(bus.lsu_done), 0);
    checkOutput("midrst_wfid", 32'(bus.lsu_done_wfid), 0);
    checkOutput("midrst_overflow", 32'(bus.overflow_err), 0);
    checkOutput("midrst_ready", 32'(bus.lsu_ready), 1);
    checkOutput("midrst_rsp_ready", 32'(bus.mem_rsp_ready), 0);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 6'd0, 4'd0, 1'b1);
    seen_done = 1'b0;
    repeat (10) begin
      step();
      if (bus.lsu_done) seen_done = 1'b1;
    end
    checkOutput("postrst_no_done", 32'(seen_done), 0);
    checkOutput("postrst_occ", 32'(bus.occupancy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
